// File: rtl/expr_tx_pkg.sv
// Shared constants for the expression character protocol: ASCII codes of the
// emitted character classes and the transmitter state encoding.
package expr_tx_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_OP    = 2'd2
  } state_t;

endpackage

// File: rtl/expr_tx_if.sv
// Character stream link between the transmitter and a consumer: one ASCII
// character moves per cycle in which out_valid and out_ready are both high.
interface expr_tx_if;

  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_char, output out_valid, input out_ready);
  modport slave  (input out_char, input out_valid, output out_ready);

endinterface

// File: rtl/expr_tx_bcd_to_ascii.sv
// Converts one BCD nibble to its ASCII digit and flags nibbles above 9.
module expr_tx_bcd_to_ascii
  import expr_tx_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii,
  output logic       over
);

  assign ascii = CH_ZERO + {4'h0, bcd};
  assign over  = (bcd > 4'd9);

endmodule

// File: rtl/expr_tx.sv
// Expression stream transmitter: latches a list of BCD operands and operators
// and emits them as "digit (op digit)*" ASCII, one character per handshake.
module expr_tx
  import expr_tx_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CW-1:0]          n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  expr_tx_if.master              tx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t               state_reg, state_next;
  logic [CW-1:0]        k_reg, k_next;
  logic [CW-1:0]        n_reg;
  logic [MAX_TERMS-2:0] ops_reg;
  logic [7:0]           chars_reg [MAX_TERMS];
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 load;

  logic [7:0]           term_ascii [MAX_TERMS];
  logic [MAX_TERMS-1:0] term_bad;
  logic                 load_ok;
  logic                 xfer;
  logic                 last;
  logic [7:0]           cur_char;
  logic                 cur_op;

  // Every term is converted up front; the ASCII form is what gets latched,
  // and only terms below n_terms may veto a load.
  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_term
    logic over;

    expr_tx_bcd_to_ascii u_conv (
      .bcd   (digits[4*gi +: 4]),
      .ascii (term_ascii[gi]),
      .over  (over)
    );

    assign term_bad[gi] = over && (CW'(gi) < n_terms);
  end

  assign load_ok = (n_terms != '0) && (n_terms <= CW'(MAX_TERMS)) && (term_bad == '0);
  assign xfer    = tx.out_valid && tx.out_ready;
  assign last    = (k_reg == n_reg - CW'(1));

  always_comb begin
    cur_char = 8'h00;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (k_reg == CW'(i)) cur_char = chars_reg[i];
    end
  end

  always_comb begin
    cur_op = 1'b0;
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (k_reg == CW'(i)) cur_op = ops_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (load_ok) begin
            load       = 1'b1;
            k_next     = '0;
            state_next = ST_DIGIT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          if (last) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (xfer) begin
          k_next     = k_reg + CW'(1);
          state_next = ST_DIGIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Payload registers carry no reset: they are only read after a fresh load.
  always_ff @(posedge clk) begin
    if (load && !clr) begin
      n_reg   <= n_terms;
      ops_reg <= ops;
      for (int i = 0; i < MAX_TERMS; i++) begin
        chars_reg[i] <= term_ascii[i];
      end
    end
  end

  assign tx.out_valid = (state_reg != ST_IDLE);
  assign tx.out_char  = (state_reg == ST_DIGIT) ? cur_char :
                        (state_reg == ST_OP)    ? (cur_op ? CH_MUL : CH_PLUS) :
                                                  8'h00;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: doc/expr_tx.md
Name: expr_tx

Overview:
Expression stream transmitter: serialises a loaded list of decimal operands and operators into an ASCII character stream, one character per accepted handshake.
- Only emitted form is digit (op digit)*, with op in {'+','*'}.
- Sits upstream of the expression checker/consumer and drives its 8-bit character input.
- Used as the stimulus source for that checker and for any consumer of the same character protocol.

Parameters:
MAX_TERMS, 8, maximum operands per expression (>=2).
CW, $clog2(MAX_TERMS+1), width of the term-count field.

Ports:
clk  in  1  clock, rising-edge.
clr  in  1  synchronous active-high reset.
start  in  1  load request; sampled only in IDLE.
n_terms  in  CW  operand count for this expression, legal 1..MAX_TERMS.
digits  in  4*MAX_TERMS  BCD operands, term i at bits [4i+3:4i].
ops  in  MAX_TERMS-1  operator i (between term i and i+1): 0='+', 1='*'.
out_char  out  8  current ASCII character.
out_valid  out  1  out_char holds a character.
out_ready  in  1  consumer accepts out_char this cycle.
busy  out  1  transmission in progress (not IDLE).
done  out  1  one-cycle pulse after the last character is accepted.
err  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset and synchronicity: one clock. clr is synchronous, active-high, and has priority over everything.
  - State returns to IDLE.
  - out_char=8'h00, out_valid=0, busy=0, done=0, err=0.
  - Latched data is don't-care after reset.
  - clr during transmission abandons the stream; no done pulse is produced.
- States: IDLE, DIGIT, OP.
- IDLE:
  - start=1 with legal n_terms and every used digit (terms 0..n_terms-1) <=9: latch digits, ops and n_terms into internal registers, clear index k=0, go to DIGIT.
  - start=1 with n_terms==0, n_terms>MAX_TERMS, or any used digit >9: err=1 for the next cycle, stay in IDLE, emit nothing.
- Latency: start accepted at edge t gives out_valid=1 with the first character in the cycle after t.
- DIGIT:
  - out_valid=1, out_char = 8'h30 + digit[k].
  - On transfer (out_valid & out_ready): if k==n_terms-1, go to IDLE and pulse done in the next cycle; otherwise go to OP.
- OP:
  - out_valid=1, out_char = ops[k] ? 8'h2A ('*') : 8'h2B ('+').
  - On transfer: k<=k+1, go to DIGIT.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_char and state hold unchanged.
  - out_valid never drops without a transfer, except on clr.
  - At most one character transfers per cycle.
  - Zero-bubble: with out_ready held high, the expression takes exactly 2*n_terms-1 consecutive valid cycles.
- Outputs in IDLE: out_valid=0 and out_char=8'h00.
- busy is 1 in DIGIT and OP only.
- done and err are mutually exclusive single-cycle pulses, each asserted the cycle after its cause.
- start while busy is ignored (no latch, no err).
- Input changes after acceptance do not affect the stream, because all inputs are latched.
- Last transfer followed by start in the same cycle as the done pulse: accepted, since the FSM is in IDLE that cycle. Back-to-back expressions therefore carry a one-cycle gap.

Decomposition:
Shared package holds:
- ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A.
- State encoding for IDLE/DIGIT/OP. The checker's character classes use the same constants.

No sub-module is needed apart from one optional combinational helper, bcd_to_ascii (4-bit in, 8-bit out, plus a >9 flag), which the validity check on start reuses.

Test Plan:
- Single term: n_terms=1, digit0=7, out_ready=1 -> one valid cycle with out_char=8'h37, then done pulse, busy low after.
- Three terms "1+2*3": digits {3,2,1}, ops=2'b10, out_ready=1 -> 5 consecutive valid cycles with out_char 31,2B,32,2A,33; done on the 6th cycle.
- Backpressure: same stream with out_ready low for 3 cycles on the 2nd character -> 8'h2B held stable for those cycles, order unchanged, 5 transfers total.
- Rejection: n_terms=2 with digit1=4'hA -> err pulse, out_valid stays 0. Separately, n_terms=0 -> err pulse.
- start while busy with different data -> ignored; the original stream completes unchanged and there is no err.
- clr asserted after the 2nd transfer of a 4-term stream -> next cycle out_valid=0, busy=0, out_char=00, no done. A fresh start then emits from term 0.
